// File: rtl/branch_predictor.sv
// IF-stage branch predictor and BTB: direct-mapped table of 2-bit counters with tags and targets.
// Lookup is combinational; the IF/ID record holds under stall; training waits for an unstalled, unflushed cycle.
module branch_predictor #(
   parameter int IDX_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [15:0]      pc_i,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic             prediction_o,
   output logic             hit_o,
   output logic [15:0]      target_o,
   output logic             prediction_id_o,
   output logic [15:0]      pc_id_o,
   input  logic             isbranch_i,
   input  logic             ifbranch_i,
   input  logic [15:0]      target_i,
   input  logic             precorrc_i,
   input  logic             prewrong_i,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = 16 - IDX_W;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [15:0]      target;
      logic [1:0]       ctr;
   } entry_t;

   typedef struct packed {
      logic [15:0] pc;
      logic        pred;
      logic        valid;
   } id_rec_t;

   localparam entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: 16'h0000, ctr: 2'b01};

   entry_t           tbl_q [ENTRIES];
   id_rec_t          id_q;
   logic [CNT_W-1:0] branch_cnt_q;
   logic [CNT_W-1:0] miss_cnt_q;

   entry_t           rd_e;
   entry_t           old_e;
   entry_t           wr_e;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic             tag_match;
   logic             upd;

   assign rd_e         = tbl_q[pc_i[IDX_W-1:0]];
   assign hit_o        = rd_e.valid && (rd_e.tag == pc_i[15:IDX_W]);
   assign prediction_o = hit_o && rd_e.ctr[1];
   assign target_o     = hit_o ? rd_e.target : 16'h0000;

   assign prediction_id_o = id_q.pred;
   assign pc_id_o         = id_q.pc;
   assign branch_cnt_o    = branch_cnt_q;
   assign miss_cnt_o      = miss_cnt_q;

   // Non-branches also get a prewrong verdict, so isbranch_i must qualify training.
   assign upd       = id_q.valid && isbranch_i && (precorrc_i || prewrong_i) && !stall_i && !flush_i;
   assign wr_idx    = id_q.pc[IDX_W-1:0];
   assign wr_tag    = id_q.pc[15:IDX_W];
   assign old_e     = tbl_q[wr_idx];
   assign tag_match = old_e.valid && (old_e.tag == wr_tag);

   always_comb begin
      wr_en = 1'b0;
      wr_e  = old_e;
      if (upd) begin
         if (tag_match) begin
            wr_en = 1'b1;
            if (ifbranch_i) begin
               if (old_e.ctr != 2'b11) wr_e.ctr = old_e.ctr + 2'b01;
               wr_e.target = target_i;
            end else if (old_e.ctr != 2'b00) begin
               wr_e.ctr = old_e.ctr - 2'b01;
            end
         end else if (ifbranch_i) begin
            wr_en = 1'b1;
            wr_e  = '{valid: 1'b1, tag: wr_tag, target: target_i, ctr: 2'b10};
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= ENTRY_RST;
         id_q         <= '0;
         branch_cnt_q <= '0;
         miss_cnt_q   <= '0;
      end else begin
         if (wr_en) tbl_q[wr_idx] <= wr_e;

         if (flush_i) begin
            id_q.valid <= 1'b0;
            id_q.pred  <= 1'b0;
         end else if (!stall_i) begin
            id_q <= '{pc: pc_i, pred: prediction_o, valid: 1'b1};
         end

         // Both verdicts high lands here as a miss through prewrong_i.
         if (upd) begin
            if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
            if (prewrong_i && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor, with a CNT_W=2 twin for counter saturation.
module tb_branch_predictor;

   logic        CLK;
   logic        RST;
   logic [15:0] pc_i;
   logic        stall_i, flush_i, isbranch_i, ifbranch_i, precorrc_i, prewrong_i;
   logic [15:0] target_i;

   logic        prediction_o, hit_o, prediction_id_o;
   logic [15:0] target_o, pc_id_o, branch_cnt_o, miss_cnt_o;

   logic        prediction2, hit2, prediction_id2;
   logic [15:0] target2, pc_id2;
   logic [1:0]  branch_cnt2, miss_cnt2;

   int checks = 0;
   int errors = 0;

   branch_predictor #(.IDX_W(4), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i),
      .prediction_o(prediction_o), .hit_o(hit_o), .target_o(target_o),
      .prediction_id_o(prediction_id_o), .pc_id_o(pc_id_o),
      .isbranch_i(isbranch_i), .ifbranch_i(ifbranch_i), .target_i(target_i),
      .precorrc_i(precorrc_i), .prewrong_i(prewrong_i),
      .branch_cnt_o(branch_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   branch_predictor #(.IDX_W(4), .CNT_W(2)) dut2 (
      .CLK(CLK), .RST(RST), .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i),
      .prediction_o(prediction2), .hit_o(hit2), .target_o(target2),
      .prediction_id_o(prediction_id2), .pc_id_o(pc_id2),
      .isbranch_i(isbranch_i), .ifbranch_i(ifbranch_i), .target_i(target_i),
      .precorrc_i(precorrc_i), .prewrong_i(prewrong_i),
      .branch_cnt_o(branch_cnt2), .miss_cnt_o(miss_cnt2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ctl = {stall, flush, isbranch, ifbranch}; vd = {precorrc, prewrong};
   // ef = {hit, prediction, prediction_id, check pc_id}
   typedef struct {
      logic [15:0] pc;
      logic [3:0]  ctl;
      logic [15:0] tgt;
      logic [1:0]  vd;
      logic [3:0]  ef;
      logic [15:0] etgt;
      logic [15:0] epc;
      int          bc;
      int          mc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [15:0] pc, input logic [3:0] ctl, input logic [15:0] tgt,
                      input logic [1:0] vd, input logic [3:0] ef, input logic [15:0] etgt,
                      input logic [15:0] epc, input int bc, input int mc);
      vec_t v;
      v.pc = pc; v.ctl = ctl; v.tgt = tgt; v.vd = vd; v.ef = ef;
      v.etgt = etgt; v.epc = epc; v.bc = bc; v.mc = mc;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int sat3(input int x);
      return (x > 3) ? 3 : x;
   endfunction

   task automatic drive(input vec_t v);
      pc_i       = v.pc;
      stall_i    = v.ctl[3];
      flush_i    = v.ctl[2];
      isbranch_i = v.ctl[1];
      ifbranch_i = v.ctl[0];
      target_i   = v.tgt;
      precorrc_i = v.vd[1];
      prewrong_i = v.vd[0];
   endtask

   initial begin
      vec_t v;
      RST = 1'b0;
      pc_i = 16'h0010; stall_i = 1'b0; flush_i = 1'b0; isbranch_i = 1'b0;
      ifbranch_i = 1'b0; target_i = 16'h0000; precorrc_i = 1'b0; prewrong_i = 1'b0;

      //   pc       ctl      tgt       vd     ef       etgt      epc       bc mc
      add(16'h0010, 4'b0000, 16'h0000, 2'b00, 4'b0001, 16'h0000, 16'h0000, 0, 0);
      add(16'h0013, 4'b0000, 16'h0000, 2'b00, 4'b0001, 16'h0000, 16'h0010, 0, 0);
      add(16'h0000, 4'b0011, 16'h0040, 2'b01, 4'b0001, 16'h0000, 16'h0013, 0, 0);
      add(16'h0013, 4'b0000, 16'h0000, 2'b00, 4'b1101, 16'h0040, 16'h0000, 1, 1);
      add(16'h0013, 4'b0011, 16'h0040, 2'b10, 4'b1111, 16'h0040, 16'h0013, 1, 1);
      add(16'h0013, 4'b0011, 16'h0040, 2'b10, 4'b1111, 16'h0040, 16'h0013, 2, 1);
      add(16'h0013, 4'b0011, 16'h0040, 2'b10, 4'b1111, 16'h0040, 16'h0013, 3, 1);
      add(16'h0013, 4'b0010, 16'h0000, 2'b01, 4'b1111, 16'h0040, 16'h0013, 4, 1);
      add(16'h0013, 4'b0010, 16'h0000, 2'b01, 4'b1111, 16'h0040, 16'h0013, 5, 2);
      add(16'h0013, 4'b0000, 16'h0000, 2'b00, 4'b1011, 16'h0040, 16'h0013, 6, 3);
      add(16'h0023, 4'b0000, 16'h0000, 2'b00, 4'b0001, 16'h0000, 16'h0013, 6, 3);
      add(16'h0013, 4'b0011, 16'h0080, 2'b01, 4'b1001, 16'h0040, 16'h0023, 6, 3);
      add(16'h0023, 4'b0000, 16'h0000, 2'b00, 4'b1101, 16'h0080, 16'h0013, 7, 4);
      add(16'h0013, 4'b0000, 16'h0000, 2'b00, 4'b0011, 16'h0000, 16'h0023, 7, 4);
      add(16'h0033, 4'b0000, 16'h0000, 2'b00, 4'b0001, 16'h0000, 16'h0013, 7, 4);
      add(16'h0023, 4'b0010, 16'h0000, 2'b10, 4'b1101, 16'h0080, 16'h0033, 7, 4);
      add(16'h0033, 4'b0000, 16'h0000, 2'b00, 4'b0011, 16'h0000, 16'h0023, 8, 4);
      add(16'h0023, 4'b0000, 16'h0000, 2'b00, 4'b1101, 16'h0080, 16'h0033, 8, 4);
      add(16'h0013, 4'b1011, 16'h00C0, 2'b01, 4'b0011, 16'h0000, 16'h0023, 8, 4);
      add(16'h0013, 4'b1011, 16'h00C0, 2'b01, 4'b0011, 16'h0000, 16'h0023, 8, 4);
      add(16'h0023, 4'b0011, 16'h00C0, 2'b10, 4'b1111, 16'h0080, 16'h0023, 8, 4);
      add(16'h0023, 4'b0000, 16'h0000, 2'b00, 4'b1111, 16'h00C0, 16'h0023, 9, 4);
      add(16'h0013, 4'b1110, 16'h0000, 2'b01, 4'b0011, 16'h0000, 16'h0023, 9, 4);
      add(16'h0023, 4'b0010, 16'h0000, 2'b01, 4'b1100, 16'h00C0, 16'h0000, 9, 4);
      add(16'h0010, 4'b0000, 16'h0000, 2'b01, 4'b0011, 16'h0000, 16'h0023, 9, 4);
      add(16'h0023, 4'b0000, 16'h0000, 2'b00, 4'b1101, 16'h00C0, 16'h0010, 9, 4);
      add(16'h0000, 4'b0011, 16'h00C0, 2'b11, 4'b0011, 16'h0000, 16'h0023, 9, 4);
      add(16'h0000, 4'b0000, 16'h0000, 2'b00, 4'b0001, 16'h0000, 16'h0000, 10, 5);

      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;

      for (int r = 0; r < vecs.size(); r++) begin
         v = vecs[r];
         drive(v);
         #1;
         chk($sformatf("r%0d hit", r),     {31'd0, hit_o},           {31'd0, v.ef[3]});
         chk($sformatf("r%0d pred", r),    {31'd0, prediction_o},    {31'd0, v.ef[2]});
         chk($sformatf("r%0d target", r),  {16'd0, target_o},        {16'd0, v.etgt});
         chk($sformatf("r%0d pred_id", r), {31'd0, prediction_id_o}, {31'd0, v.ef[1]});
         if (v.ef[0]) chk($sformatf("r%0d pc_id", r), {16'd0, pc_id_o}, {16'd0, v.epc});
         chk($sformatf("r%0d branch_cnt", r), {16'd0, branch_cnt_o}, v.bc);
         chk($sformatf("r%0d miss_cnt", r),   {16'd0, miss_cnt_o},   v.mc);
         chk($sformatf("r%0d branch_cnt2", r), {30'd0, branch_cnt2}, sat3(v.bc));
         chk($sformatf("r%0d miss_cnt2", r),   {30'd0, miss_cnt2},   sat3(v.mc));
         @(posedge CLK);
         #1;
      end

      // Reset in the middle of a pending training cycle.
      pc_i = 16'h0023; stall_i = 1'b0; flush_i = 1'b0; isbranch_i = 1'b0;
      ifbranch_i = 1'b0; precorrc_i = 1'b0; prewrong_i = 1'b0;
      @(posedge CLK);
      #1;
      chk("pre-reset pred_id", {31'd0, prediction_id_o}, 32'd1);
      RST = 1'b0; isbranch_i = 1'b1; prewrong_i = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b1; isbranch_i = 1'b0; prewrong_i = 1'b0;
      #1;
      chk("mid-reset hit",        {31'd0, hit_o},           32'd0);
      chk("mid-reset pred",       {31'd0, prediction_o},    32'd0);
      chk("mid-reset target",     {16'd0, target_o},        32'd0);
      chk("mid-reset pred_id",    {31'd0, prediction_id_o}, 32'd0);
      chk("mid-reset pc_id",      {16'd0, pc_id_o},         32'd0);
      chk("mid-reset branch_cnt", {16'd0, branch_cnt_o},    32'd0);
      chk("mid-reset miss_cnt",   {16'd0, miss_cnt_o},      32'd0);
      chk("mid-reset miss_cnt2",  {30'd0, miss_cnt2},       32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

IF-stage branch predictor and branch target buffer for the 16-bit pipeline. It sits directly upstream of the hazard unit:
- Each fetch cycle it looks up the fetch PC and returns a taken/not-taken prediction and a predicted target.
- It carries that prediction alongside the instruction into ID as `prediction_id_o`, which drives the hazard unit's `prediction_i`.
- It trains its table from the hazard unit's `precorrc_o`/`prewrong_o` verdicts and the resolved branch outcome.

## Interface
Parameters:
- `IDX_W`, default 4: index width; the table has 2^IDX_W entries, indexed by `pc[IDX_W-1:0]`, with tag `pc[15:IDX_W]`.
- `CNT_W`, default 16: width of each statistics counter.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous, active-low.
- `pc_i`  in  16  fetch PC of the instruction in IF.
- `stall_i`  in  1  hold the IF/ID record (load-use stall).
- `flush_i`  in  1  invalidate the IF/ID record (IF flush or interception).
- `prediction_o`  out  1  combinational taken prediction for `pc_i`.
- `hit_o`  out  1  combinational BTB hit for `pc_i`.
- `target_o`  out  16  combinational predicted target; 0 when `hit_o` = 0.
- `prediction_id_o`  out  1  registered prediction of the instruction in ID; goes to the hazard unit.
- `pc_id_o`  out  16  registered PC of the instruction in ID.
- `isbranch_i`  in  1  the instruction in ID is a conditional branch.
- `ifbranch_i`  in  1  resolved outcome, 1 = taken.
- `target_i`  in  16  resolved branch target.
- `precorrc_i`, `prewrong_i`  in  1  verdicts from the hazard unit.
- `branch_cnt_o`  out  CNT_W  trained branches.
- `miss_cnt_o`  out  CNT_W  mispredicted branches.

## Operation
Table entry fields: `valid`, `tag[15-IDX_W:0]`, `target[15:0]`, `ctr[1:0]` (saturating counter).

Lookup (combinational):
- hit = `valid[i]` && `tag[i]` == `pc_i[15:IDX_W]`.
- `prediction_o` = hit && `ctr[i][1]`.
- `target_o` = hit ? `target[i]` : 0.

IF/ID record (`pc_id`, `pred_id`, `valid_id`), evaluated each edge in priority order:
1. `RST`=0: everything clears to 0.
2. `flush_i`=1: `valid_id`=0, `pred_id`=0; `pc_id` is don't-care.
3. `stall_i`=1: hold.
4. Otherwise: `pc_id`<=`pc_i`, `pred_id`<=`prediction_o`, `valid_id`<=1.

Outputs: `prediction_id_o` = `pred_id`, `pc_id_o` = `pc_id`.

Train condition: `upd` = `valid_id` && `isbranch_i` && (`precorrc_i` || `prewrong_i`) && !`stall_i` && !`flush_i`. The hazard unit asserts `prewrong` for non-branches, so the `isbranch_i` qualifier is mandatory. Training uses index j = `pc_id[IDX_W-1:0]` and tag t = `pc_id[15:IDX_W]`.

On `upd`:
- **Tag match** (`valid[j]` && `tag[j]`==t):
  - `ifbranch_i`=1: `ctr` increments, saturating at 11; `target[j]`<=`target_i`.
  - `ifbranch_i`=0: `ctr` decrements, saturating at 00; entry stays valid.
- **Miss, `ifbranch_i`=1**: allocate (replace any occupant): `valid`=1, `tag`=t, `target`=`target_i`, `ctr`=10.
- **Miss, `ifbranch_i`=0**: table unchanged.

Statistics:
- On `upd`, `branch_cnt` increments.
- On `upd` && `prewrong_i`, `miss_cnt` also increments.
- Both saturate at all-ones; they do not wrap.

Reset state: all `valid`=0, `ctr`=01, `tag`/`target`=0, record=0, counters=0.

## Timing
- Lookup latency is 0 cycles; the prediction for `pc_i` reaches the ID-side outputs 1 cycle later.
- A write at edge k is visible to lookups from cycle k+1 onward.
- Same-cycle read and update of the same index: the lookup returns pre-update contents (no bypass).
- `stall_i` and `flush_i` together: flush wins.
- Training is blocked while stalled, because the hazard unit defers its verdict until the stall clears. The update happens on the first unstalled cycle.
- Reset asserted mid-operation: state is cleared at that edge; a pending update is dropped and the counters clear.
- `precorrc_i` and `prewrong_i` both high is illegal; if it occurs, treat it as a miss.

## Test plan
- **Reset:** `RST`=0 for 2 cycles then release; `pc_i`=0x0010 -> `hit_o`=0, `prediction_o`=0, `target_o`=0, `prediction_id_o`=0, both counters 0.
- **Allocate and predict:** fetch 0x0013; next cycle `isbranch_i`=1, `ifbranch_i`=1, `target_i`=0x0040, `prewrong_i`=1; then fetch 0x0013 -> `hit_o`=1, `prediction_o`=1, `target_o`=0x0040, `miss_cnt_o`=1, `branch_cnt_o`=1.
- **Saturation:** train 0x0013 taken 3 more times -> `ctr`=11. Then train not-taken twice -> `ctr`=01, `prediction_o`=0, `hit_o`=1.
- **Alias:** with 0x0013 allocated, train 0x0023 (same index, tag differs) taken -> lookup 0x0013 gives `hit_o`=0; lookup 0x0023 gives target=`target_i`. Training 0x0033 not-taken leaves the table unchanged.
- **Stall/flush:** hold `stall_i`=1 for 2 cycles with `prewrong_i`=1 -> no table or counter change and `pc_id_o` held. Assert `stall_i` and `flush_i` together -> `prediction_id_o`=0, no update.
- **Non-branch verdict and counter saturation:** `isbranch_i`=0, `prewrong_i`=1 -> no update. With `CNT_W`=2, perform 5 mispredicted updates -> `miss_cnt_o`=3 (saturated, not wrapped).
